seven_seg_scanner: RTL and testbench

Time-multiplexed scan driver for the board's 8-digit common-anode seven-segment display. It sits directly upstream of `seven_seg_decoder`, presenting one 4-bit hex nibble at a time on `number` and the matching active-low `anode` enable. A refresh divider advances the scan, and a double-buffered value register means a new 32-bit word only reaches the display at a frame boundary, so digits never tear. Optional per-digit masking and leading-zero blanking are applied during the scan.

---
 rtl/seven_seg_scanner_pkg.sv | 22 ++
 rtl/seven_seg_scanner_refresh_divider.sv | 29 ++
 rtl/seven_seg_scanner.sv | 90 +++++++++
 tb/tb_seven_seg_scanner.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_scanner_pkg.sv
// Shared definitions for the seven-segment scan driver: digit count,
// the all-dark anode pattern, digit index type and a most-significant-digit helper.
package seg_pkg;

    localparam int NUM_DIGITS = 8;
    localparam logic [7:0] ANODE_OFF = 8'hFF;

    typedef logic [2:0] digit_idx_t;

    // Index of the highest nonzero nibble, 0 when the whole word is zero.
    function automatic digit_idx_t msd_of(input logic [31:0] word);
        digit_idx_t m;
        m = 3'd0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (word[4*k +: 4] != 4'h0) begin
                m = digit_idx_t'(k);
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/seven_seg_scanner_refresh_divider.sv
// Free-running refresh divider: counts 0..DIV-1 and flags the terminal count,
// which paces the digit scan.
module refresh_divider #(
    parameter int DIV = 100000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_r;

    // Divider counter, wrapping on the terminal count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (cnt_r == LAST) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + 1'b1;
        end
    end

    assign tick = (cnt_r == LAST);

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed 8-digit common-anode scan driver with a double-buffered
// display word, per-digit masking and leading-zero blanking.
module seven_seg_scanner
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int NUM_DIGITS  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    blank_lz,
    output logic [3:0]              number,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    frame_done
);

    logic       tick_s;
    logic       wrap_s;
    digit_idx_t idx_r;
    digit_idx_t msd_s;
    logic [31:0] pending_r;
    logic [31:0] shown_r;
    logic        pend_v_r;
    // Nothing is lit until a word has been committed since reset.
    logic        shown_v_r;
    logic [7:0]  anode_next_s;

    refresh_divider #(.DIV(REFRESH_DIV)) u_div (
        .clk   (clk),
        .reset (reset),
        .tick  (tick_s)
    );

    // Wrap detection and per-digit lit/dark decision for the current slot.
    always_comb begin
        msd_s        = msd_of(shown_r);
        wrap_s       = tick_s && (idx_r == 3'd7);
        anode_next_s = ANODE_OFF;
        if (shown_v_r && digit_en[idx_r] && !(blank_lz && (idx_r > msd_s))) begin
            anode_next_s = ~(8'h01 << idx_r);
        end else begin
            anode_next_s = ANODE_OFF;
        end
    end

    // Scan index and registered display outputs, updated on each tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_r      <= 3'd0;
            anode      <= ANODE_OFF;
            number     <= 4'h0;
            frame_done <= 1'b0;
        end else if (tick_s) begin
            idx_r      <= idx_r + 3'd1;
            anode      <= anode_next_s;
            number     <= shown_r[4*idx_r +: 4];
            frame_done <= (idx_r == 3'd0);
        end else begin
            frame_done <= 1'b0;
        end
    end

    // Double buffer: a load at the wrap bypasses the pending stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_r <= 32'h0;
            shown_r   <= 32'h0;
            pend_v_r  <= 1'b0;
            shown_v_r <= 1'b0;
        end else if (wrap_s && load) begin
            shown_r   <= value;
            shown_v_r <= 1'b1;
            pend_v_r  <= 1'b0;
        end else if (wrap_s && pend_v_r) begin
            shown_r   <= pending_r;
            shown_v_r <= 1'b1;
            pend_v_r  <= 1'b0;
        end else if (load) begin
            pending_r <= value;
            pend_v_r  <= 1'b1;
        end else begin
            pending_r <= pending_r;
            pend_v_r  <= pend_v_r;
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner with REFRESH_DIV=4: cycle reference
// model derived from elapsed time, table of display vectors, corner sequences, random load traffic.
module tb_seven_seg_scanner;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] value = 32'h0;
    logic        load = 1'b0;
    logic [7:0]  digit_en = 8'hFF;
    logic        blank_lz = 1'b0;
    logic [3:0]  number;
    logic [7:0]  anode;
    logic        frame_done;

    int n_tests = 0;
    int n_fail  = 0;

    seven_seg_scanner #(.REFRESH_DIV(4), .NUM_DIGITS(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .value      (value),
        .load       (load),
        .digit_en   (digit_en),
        .blank_lz   (blank_lz),
        .number     (number),
        .anode      (anode),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Reference model: time since reset release decides slot and digit.
    int          mt;
    logic [31:0] m_pend, m_shown;
    bit          m_pv, m_sv;
    logic [7:0]  e_anode;
    logic [3:0]  e_num;
    logic        e_fd;

    function automatic int m_msd(input logic [31:0] w);
        for (int k = 7; k >= 0; k--) begin
            if (((w >> (4 * k)) & 32'hF) != 32'h0) return k;
        end
        return 0;
    endfunction

    task automatic m_reset();
        mt = 0; m_pend = 32'h0; m_shown = 32'h0; m_pv = 0; m_sv = 0;
        e_anode = 8'hFF; e_num = 4'h0; e_fd = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timeout waiting for display event (t=%0t)", nm, $time);
    endtask

    task automatic step();
        int  idx;
        bit  tk;
        logic [7:0] one;
        @(posedge clk);
        if (reset) begin
            m_reset();
        end else begin
            idx = (mt / 4) % 8;
            tk  = (mt % 4) == 3;
            one = 8'h01;
            if (tk) begin
                if (m_sv && digit_en[idx] && !(blank_lz && idx > m_msd(m_shown)))
                    e_anode = ~(one << idx);
                else
                    e_anode = 8'hFF;
                e_num = 4'((m_shown >> (4 * idx)) & 32'hF);
                e_fd  = (idx == 0);
            end else begin
                e_fd = 1'b0;
            end
            if (tk && idx == 7 && load) begin
                m_shown = value; m_sv = 1; m_pv = 0;
            end else if (tk && idx == 7 && m_pv) begin
                m_shown = m_pend; m_sv = 1; m_pv = 0;
            end else if (load) begin
                m_pend = value; m_pv = 1;
            end
            mt++;
        end
        #1;
        chk("anode", 32'(anode), 32'(e_anode));
        chk("number", 32'(number), 32'(e_num));
        chk("frame_done", 32'(frame_done), 32'(e_fd));
    endtask

    task automatic do_load(input logic [31:0] v);
        value = v; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic wait_fd(input string nm);
        int n;
        n = 0;
        while (e_fd !== 1'b1 && n < 400) begin step(); n++; end
        if (e_fd !== 1'b1) timeout(nm);
    endtask

    task automatic wait_anode(input logic [7:0] a, input string nm);
        int n;
        n = 0;
        while (e_anode !== a && n < 400) begin step(); n++; end
        if (e_anode !== a) timeout(nm);
    endtask

    task automatic do_midreset();
        #2 reset = 1'b1;
        #1;
        chk("reset_anode", 32'(anode), 32'h0000_00FF);
        chk("reset_number", 32'(number), 32'h0);
        chk("reset_fd", 32'(frame_done), 32'h0);
        m_reset();
        step();
        reset = 1'b0;
    endtask

    typedef struct {
        logic [31:0] value;
        logic [7:0]  den;
        logic        blz;
        logic [7:0]  exp_lit;
        logic [3:0]  exp_d0;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [7:0] lit;
        logic [7:0] one;
        one = 8'h01;
        m_reset();
        vecs[0] = '{32'h76543210, 8'hFF, 1'b0, 8'hFF, 4'h0};
        vecs[1] = '{32'h000000A5, 8'hFF, 1'b1, 8'h03, 4'h5};
        vecs[2] = '{32'h00000000, 8'hFF, 1'b1, 8'h01, 4'h0};
        vecs[3] = '{32'hFFFFFFFF, 8'h0F, 1'b0, 8'h0F, 4'hF};
        vecs[4] = '{32'h00F00000, 8'hFF, 1'b1, 8'h3F, 4'h0};
        vecs[5] = '{32'h12345678, 8'hAA, 1'b0, 8'hAA, 4'h8};
        vecs[6] = '{32'h00000300, 8'hF0, 1'b1, 8'h00, 4'h0};

        step(); step();
        chk("por_anode", 32'(anode), 32'h0000_00FF);
        #3 reset = 1'b0;

        // Reset and scan: dark first frame, then FE..7F with numbers 0..7.
        do_load(32'h76543210);
        lit = 8'h00;
        for (int i = 0; i < 32; i++) begin step(); lit |= ~anode; end
        chk("first_frame_dark", 32'(lit), 32'h0);
        wait_fd("scan_fd");
        for (int k = 0; k < 8; k++) begin
            chk("scan_anode", 32'(anode), 32'(8'(~(one << k))));
            chk("scan_number", 32'(number), k);
            for (int c = 0; c < 4; c++) step();
        end
        chk("fd_period", 32'(frame_done), 32'h1);

        // Tear-free update: digits 4..7 keep the old word until the wrap.
        wait_anode(8'hF7, "tear_d3");
        do_load(32'hFFFFFFFF);
        wait_anode(8'hEF, "tear_d4");
        chk("tear_d4_old", 32'(number), 32'h4);
        wait_anode(8'h7F, "tear_d7");
        chk("tear_d7_old", 32'(number), 32'h7);
        wait_fd("tear_fd");
        chk("tear_d0_new", 32'(number), 32'hF);

        // Table of display words, masks and blanking settings.
        for (int v = 0; v < 7; v++) begin
            digit_en = vecs[v].den;
            blank_lz = vecs[v].blz;
            do_load(vecs[v].value);
            wait_fd("tbl_fd1");
            step();
            wait_fd("tbl_fd2");
            chk("tbl_d0_number", 32'(number), 32'(vecs[v].exp_d0));
            lit = ~anode;
            for (int i = 0; i < 31; i++) begin step(); lit |= ~anode; end
            chk("tbl_lit_mask", 32'(lit), 32'(vecs[v].exp_lit));
        end
        digit_en = 8'hFF;
        blank_lz = 1'b0;

        // Load coinciding with the 7->0 wrap overrides an older pending word.
        do_load(32'h22222222);
        begin
            int n;
            n = 0;
            while (mt % 32 != 31 && n < 100) begin step(); n++; end
        end
        do_load(32'h11111111);
        wait_fd("wrap_fd");
        chk("wrap_d0", 32'(number), 32'h1);
        chk("wrap_d0_anode", 32'(anode), 32'h0000_00FE);
        step();
        wait_fd("wrap_fd2");
        chk("wrap_no_stale", 32'(number), 32'h1);

        // Mid-scan reset with a pending word.
        do_load(32'h99999999);
        wait_anode(8'hDF, "rst_d5");
        do_midreset();
        do_load(32'h12121212);
        lit = 8'h00;
        for (int i = 0; i < 32; i++) begin step(); lit |= ~anode; end
        chk("post_reset_dark", 32'(lit), 32'h0);
        wait_fd("post_reset_fd");
        chk("post_reset_d0", 32'(number), 32'h2);
        chk("post_reset_anode", 32'(anode), 32'h0000_00FE);

        // Random load traffic, masks, blanking and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            value = $urandom;
            if ($urandom_range(0, 3) == 0) value = value & 32'h0000_0FFF;
            load = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 99) == 0) digit_en = 8'($urandom);
            if ($urandom_range(0, 99) == 0) blank_lz = ~blank_lz;
            step();
            load = 1'b0;
            if ($urandom_range(0, 999) == 0) do_midreset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
